// File: rtl/four_bit_comp.sv
// Registered unsigned magnitude comparator: captures a/b on a qualified edge and
// presents one-hot greater/equal/smaller flags one clock later.
module four_bit_comp #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [WIDTH:1] a,
  input  logic [WIDTH:1] b,
  output logic           g,
  output logic           e,
  output logic           s,
  output logic           out_valid
);

  logic gt;
  logic eq;
  logic lt;

  // Vectors are unsigned, so the native relational operators give the
  // magnitude compare directly. Exactly one of the three terms is true.
  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

  // Flags hold their last result while in_valid is low. out_valid only
  // reports whether the most recent edge carried a new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so process order never matters.
      g         <= 1'b0;
      e         <= 1'b0;
      s         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        g <= gt;
        e <= eq;
        s <= lt;
      end
    end
  end

endmodule

// File: tb/tb_four_bit_comp.sv
// Directed and exhaustive checks of four_bit_comp: reset, latency, hold,
// input-insensitivity between edges and asynchronous reset.
module tb_four_bit_comp;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [4:1] a;
  logic [4:1] b;
  logic       g;
  logic       e;
  logic       s;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  four_bit_comp #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .g         (g),
    .e         (e),
    .s         (s),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {out_valid, g, e, s} for a valid capture.
  function automatic logic [3:0] model(input logic [4:1] x, input logic [4:1] y);
    int ux;
    int uy;
    ux = int'(x);
    uy = int'(y);
    return {1'b1, ux > uy, ux == uy, ux < uy};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed {ov,g,e,s}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Drive operands on the falling edge, let one rising edge capture them,
  // then sample on the next falling edge.
  task automatic apply(input logic v, input logic [4:1] x, input logic [4:1] y);
    in_valid = v;
    a        = x;
    b        = y;
    @(negedge clk);
  endtask

  initial begin
    logic [4:1] va [6];
    logic [4:1] vb [6];
    logic [4:1] ba [4];
    logic [4:1] bb [4];
    logic [3:0] bexp [4];
    va = '{4'b0000, 4'b1010, 4'b0100, 4'b0001, 4'ha, 4'b0100};
    vb = '{4'b0000, 4'b0101, 4'b1000, 4'b1110, 4'hf, 4'b0100};
    ba = '{4'd0, 4'd15, 4'd0, 4'd15};
    bb = '{4'd15, 4'd0, 4'd0, 4'd15};
    bexp = '{4'b1001, 4'b1100, 4'b1010, 4'b1010};

    // Reset held with a valid operand pair and running clock.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'b1010;
    b        = 4'b0101;
    repeat (3) @(negedge clk);
    check("reset_hold", {out_valid, g, e, s}, 4'b0000);

    // First valid edge after release already produces a result.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, va[i], vb[i]);
      check($sformatf("directed_%0d", i), {out_valid, g, e, s},
            (i == 0 || i == 5) ? 4'b1010 : (i == 1) ? 4'b1100 : 4'b1001);
    end

    for (int i = 0; i < 4; i++) begin
      apply(1'b1, ba[i], bb[i]);
      check($sformatf("boundary_%0d", i), {out_valid, g, e, s}, bexp[i]);
    end

    // Hold: flags keep the last result, out_valid drops.
    apply(1'b1, 4'b1010, 4'b0101);
    check("hold_setup", {out_valid, g, e, s}, 4'b1100);
    apply(1'b0, 4'b0000, 4'b1111);
    check("hold_1", {out_valid, g, e, s}, 4'b0100);
    apply(1'b0, 4'b0000, 4'b1111);
    check("hold_2", {out_valid, g, e, s}, 4'b0100);

    // Exhaustive: operands are scrambled right after the capturing edge, so a
    // combinational path or a late sample shows up as a wrong flag.
    for (int i = 0; i < 256; i++) begin
      logic [4:1] x;
      logic [4:1] y;
      x = 4'(i >> 4);
      y = 4'(i);
      in_valid = 1'b1;
      a        = x;
      b        = y;
      @(posedge clk);
      #1;
      a        = ~x;
      b        = y ^ 4'b0110;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("exh_%0d_%0d", x, y), {out_valid, g, e, s}, model(x, y));
      check("onehot", 4'($countones({g, e, s})), 4'd1);
    end

    // Asynchronous reset between edges while e=1.
    apply(1'b1, 4'd7, 4'd7);
    check("async_pre", {out_valid, g, e, s}, 4'b1010);
    in_valid = 1'b1;
    a        = 4'd9;
    b        = 4'd3;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", {out_valid, g, e, s}, 4'b0000);
    @(negedge clk);
    check("async_held", {out_valid, g, e, s}, 4'b0000);

    // Pending operands were discarded; recovery is immediate.
    rst_n = 1'b1;
    apply(1'b0, 4'd9, 4'd3);
    check("post_reset_idle", {out_valid, g, e, s}, 4'b0000);
    apply(1'b1, 4'd2, 4'd11);
    check("post_reset_valid", {out_valid, g, e, s}, 4'b1001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
